// File: rtl/audio_soft_mute.sv
// Click-free soft mute: linear gain ramp 0..FULL applied to a signed sample
// stream, one gain step per accepted sample, with ramp status for polling/IRQ.
module audio_soft_mute #(
  parameter int DATA_W    = 16,
  parameter int RAMP_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     unmute_en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [RAMP_LOG2:0]       gain,
  output logic [1:0]               state,
  output logic                     ramp_done
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = DATA_W + RAMP_LOG2 + 2;
  localparam logic [GW-1:0] FULL = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PASS      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t            st_q, st_nxt;
  logic [GW-1:0]     gain_nxt;
  logic signed [PW-1:0] din_x, gain_x, prod;

  // Step only on accepted samples; saturation falls out of the guards.
  always_comb begin
    gain_nxt = gain;
    if (in_valid) begin
      if (unmute_en && gain != FULL)
        gain_nxt = gain + 1'b1;
      else if (!unmute_en && gain != '0)
        gain_nxt = gain - 1'b1;
    end
  end

  always_comb begin
    st_nxt = MUTED;
    if (unmute_en)
      st_nxt = (gain_nxt == FULL) ? PASS : RAMP_UP;
    else
      st_nxt = (gain_nxt == '0) ? MUTED : RAMP_DOWN;
  end

  // Gain is non-negative, so zero-extend it before the signed multiply.
  assign din_x  = PW'(in_data);
  assign gain_x = PW'(gain);
  assign prod   = din_x * gain_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain      <= '0;
      st_q      <= MUTED;
      out_valid <= 1'b0;
      out_data  <= '0;
      ramp_done <= 1'b0;
    end else begin
      gain      <= gain_nxt;
      st_q      <= st_nxt;
      out_valid <= in_valid;
      if (in_valid)
        out_data <= DATA_W'(prod >>> RAMP_LOG2);
      ramp_done <= in_valid && (gain_nxt != gain) &&
                   (gain_nxt == FULL || gain_nxt == '0);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_audio_soft_mute.sv
// Scoreboard bench for audio_soft_mute: stimulus pushes model expectations,
// an independent monitor pops and compares one entry per clock.
module tb_audio_soft_mute;
  localparam int DATA_W = 16;
  localparam int RL2    = 2;
  localparam int FULL   = 1 << RL2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     unmute_en;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [RL2:0]             gain;
  logic [1:0]               state;
  logic                     ramp_done;

  audio_soft_mute #(.DATA_W(DATA_W), .RAMP_LOG2(RL2)) dut (
    .clk(clk), .reset_n(reset_n), .unmute_en(unmute_en), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .gain(gain), .state(state), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ov;
    int od;
    int g;
    int st;
    int rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_gain = 0;
  int   m_out  = 0;
  int   rd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by FULL (arithmetic shift semantics, rounds to -inf).
  function automatic int fdiv(input int a);
    int r;
    r = a / FULL;
    if ((a % FULL) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  task automatic step(input bit en, input bit v, input int d);
    exp_t e;
    int   ng;
    @(posedge clk);
    #2;
    unmute_en = en;
    in_valid  = v;
    in_data   = DATA_W'(d);
    ng = m_gain;
    if (v) begin
      m_out = fdiv(d * m_gain);
      if (en && m_gain < FULL) ng = m_gain + 1;
      else if (!en && m_gain > 0) ng = m_gain - 1;
    end
    e.ov = v;
    e.od = m_out;
    e.g  = ng;
    e.rd = (v && ng != m_gain && (ng == 0 || ng == FULL)) ? 1 : 0;
    if (en) e.st = (ng == FULL) ? 2 : 1;
    else    e.st = (ng == 0) ? 0 : 3;
    m_gain = ng;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gain"},      int'(gain), 0);
    chk({tag, "_state"},     int'(state), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_ramp_done"}, int'(ramp_done), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_valid", int'(out_valid), e.ov);
        chk("out_data",  int'(out_data), e.od);
        chk("gain",      int'(gain), e.g);
        chk("state",     int'(state), e.st);
        chk("ramp_done", int'(ramp_done), e.rd);
        if (ramp_done) rd_cnt++;
      end
    end
  end

  initial begin : stim
    int rc0;
    bit en;
    reset_n   = 1'b0;
    unmute_en = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Unmute ramp with constant 1000: 0,250,500,750,1000,1000...
    rc0 = rd_cnt;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1000);
    // Mute ramp with -1000.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, -1000);
    step(1'b0, 1'b0, 0);
    chk("ramp_done_pulses_up_down", rd_cnt - rc0, 2);

    // Rounding at gain 1.
    step(1'b1, 1'b1, 7);
    step(1'b0, 1'b1, -1);
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, -32768);
    step(1'b0, 1'b0, 0);

    // Reversal mid-ramp: one ramp_done only at 0.
    rc0 = rd_cnt;
    step(1'b1, 1'b1, 400);
    step(1'b1, 1'b1, 400);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 400);
    step(1'b0, 1'b0, 0);
    chk("ramp_done_reversal", rd_cnt - rc0, 1);

    // Sparse samples: state moves on en alone, gain only on strobes.
    for (int i = 0; i < 30; i++) step(1'b1, (i % 5) == 0, 1200 - i * 100);

    // Toggle at an endpoint without gain change: no pulse.
    rc0 = rd_cnt;
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);
    chk("ramp_done_endpoint_toggle", rd_cnt - rc0, 0);

    // Async reset mid-ramp at gain 3.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2000);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_gain = 0;
    m_out  = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, -2000);

    // Randomized traffic with occasional direction flips.
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) en = ~en;
      step(en, $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768);
    end
    step(1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_soft_mute.md
Name: audio_soft_mute

Overview:
- Click-free mute/unmute stage that sits directly downstream of the 1-bit control PIO in the AGC datapath.
- The PIO `out_port` drives `unmute_en`.
- Applies a linear gain ramp (0 to unity) to a streaming signed audio sample bus, one gain step per accepted sample.
- Reports ramp status back for software polling or IRQ.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- RAMP_LOG2, 8, ramp length = 2^RAMP_LOG2 samples; unity gain FULL = 2^RAMP_LOG2

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- unmute_en  in  1  1 = pass audio, 0 = mute; synchronous to clk (from PIO)
- in_valid  in  1  input sample strobe
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  output sample strobe
- out_data  out  DATA_W  signed gained sample
- gain  out  RAMP_LOG2+1  current gain, 0..FULL
- state  out  2  0 MUTED, 1 RAMP_UP, 2 PASS, 3 RAMP_DOWN
- ramp_done  out  1  one-cycle pulse when gain reaches 0 or FULL

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. While asserted:
  - gain = 0, state = MUTED, out_valid = 0, out_data = 0, ramp_done = 0.
  - Reset mid-ramp aborts immediately to this state.
- No backpressure. Every in_valid cycle is one sample, and in_valid may be high every cycle.
- Latency is exactly 1 clk:
  - out_valid(t+1) = in_valid(t).
  - out_data(t+1) = (in_data(t) * gain(t)) >>> RAMP_LOG2.
- Arithmetic:
  - Signed multiply at full width DATA_W+RAMP_LOG2+2.
  - Arithmetic right shift truncates toward minus infinity.
  - Result is taken as the low DATA_W bits. Overflow is impossible because gain <= FULL.
  - At gain = FULL, out_data equals in_data exactly. At gain = 0, out_data = 0.
- out_data holds its last value when in_valid = 0.
- Gain update happens only on in_valid cycles; the sample in that cycle uses the old gain.
  - unmute_en=1 and gain<FULL: gain += 1.
  - unmute_en=0 and gain>0: gain -= 1.
  - Otherwise gain holds.
  - Direction is sampled from unmute_en in the same cycle.
- Reversal: a toggle of unmute_en mid-ramp reverses direction from the current gain. There is no jump and no restart.
- state is a registered value computed from the next gain and the current unmute_en:
  - next gain == 0 and en = 0: MUTED.
  - next gain == FULL and en = 1: PASS.
  - next gain < FULL and en = 1: RAMP_UP.
  - next gain > 0 and en = 0: RAMP_DOWN.
  - Consequence: MUTED -> RAMP_UP one cycle after en rises, even with no samples flowing.
- ramp_done:
  - Registered pulse in the cycle where gain transitions to FULL (from FULL-1) or to 0 (from 1).
  - No pulse when a reversal occurs before an endpoint.
  - No pulse when en toggles while already at an endpoint without a gain change.
- gain never wraps. Saturation at 0 and FULL is inherent in the update rule.

Test Plan:
- Bench uses RAMP_LOG2=2 (FULL=4) unless noted.
- Reset then en=1, in_data=1000 held, in_valid every cycle:
  - out_data = 0, 250, 500, 750, 1000, 1000...
  - state goes 0 -> 1 -> 2; ramp_done pulses once as gain hits 4.
- From PASS, en=0, in_data=-1000:
  - out_data = -1000, -750, -500, -250, 0.
  - state goes 2 -> 3 -> 0; ramp_done pulses once at gain 0.
- Rounding check: gain=1, in_data=-1 -> out_data=-1; in_data=3 -> 0; in_data=-32768 -> -8192.
- Reversal: en=1 for 2 samples (gain=2), then en=0 ->
  - gain 1, then 0; state 1 -> 3 -> 0.
  - Exactly one ramp_done, at 0.
- Sparse samples: in_valid once every 5 cycles with en=1:
  - gain steps only on valid cycles; out_valid is a 1-cycle-delayed copy.
  - out_data is stable between strobes.
- Async reset asserted at gain=3 mid-ramp:
  - gain, out_data, out_valid go to 0 immediately; state=MUTED.
  - After release with en=1, the ramp restarts from 0.
